// File: rtl/dut_cmd_pkg.sv
// rtl/dut_cmd_pkg.sv - shared opcodes, sizes and response type for the command slave
package dut_cmd_pkg;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 4;
    localparam int ADR_W    = 4;
    localparam int CMD_W    = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP     = 4'd0,
        CMD_WRITE   = 4'd1,
        CMD_READ    = 4'd2,
        CMD_INC     = 4'd3,
        CMD_CLR_ALL = 4'd4
    } cmd_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } rsp_t;

    function automatic logic is_legal(input logic [CMD_W-1:0] cmd);
        return cmd <= CMD_CLR_ALL;
    endfunction

endpackage

// File: rtl/dut_rsp_fifo.sv
// rtl/dut_rsp_fifo.sv - synchronous response FIFO; pop frees a slot for a same-edge push
module dut_rsp_fifo
    import dut_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  rsp_t push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output rsp_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    rsp_t            mem [DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/dut_cmd_slave.sv
// rtl/dut_cmd_slave.sv - bus command consumer: 16x4 register array, clear sweep, read response FIFO
module dut_cmd_slave
    import dut_cmd_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADR_W-1:0]  rsp_adr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  illegal_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ADR_W-1:0] LAST_IDX = ADR_W'(NUM_REGS - 1);

    state_e            state_q;
    state_e            state_d;
    logic [ADR_W-1:0]  sweep_idx;
    logic [DATA_W-1:0] reg_file [NUM_REGS];

    logic do_write;
    logic do_inc;
    logic do_read;
    logic illegal_hit;
    logic drop_hit;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    rsp_t push_rsp;
    rsp_t fifo_head;

    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (state_q == ST_CLEAR);
    assign push_rsp  = {adr, reg_file[adr]};
    assign rsp_adr   = fifo_head.adr;
    assign rsp_data  = fifo_head.data;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        do_write    = 1'b0;
        do_inc      = 1'b0;
        do_read     = 1'b0;
        illegal_hit = 1'b0;
        drop_hit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!is_legal(cmd)) begin
                    illegal_hit = 1'b1;
                end else begin
                    case (cmd)
                        CMD_WRITE:   do_write = 1'b1;
                        CMD_INC:     do_inc   = 1'b1;
                        CMD_CLR_ALL: state_d  = ST_CLEAR;
                        CMD_READ: begin
                            // A pop on the same edge frees the slot, so only a stalled full FIFO drops.
                            if (fifo_full && !pop) drop_hit = 1'b1;
                            else                   do_read  = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (cmd != CMD_NOP)       drop_hit = 1'b1;
                if (sweep_idx == LAST_IDX) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || state_q == ST_IDLE) sweep_idx <= '0;
        else                           sweep_idx <= sweep_idx + ADR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
        end else if (state_q == ST_CLEAR) begin
            reg_file[sweep_idx] <= '0;
        end else if (do_write) begin
            reg_file[adr] <= data;
        end else if (do_inc) begin
            reg_file[adr] <= reg_file[adr] + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (illegal_hit && illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + CNT_W'(1);
            if (drop_hit && drop_cnt != CNT_MAX)       drop_cnt    <= drop_cnt + CNT_W'(1);
        end
    end

    dut_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (do_read),
        .push_data(push_rsp),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    a_cmd_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(cmd));

endmodule

// File: tb/tb_dut_cmd_slave.sv
// tb/tb_dut_cmd_slave.sv - directed and random stimulus against a queue-based reference model
module tb_dut_cmd_slave;
    import dut_cmd_pkg::*;

    localparam int RSP_DEPTH = 4;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       cmd = '0;
    logic [3:0]       adr = '0;
    logic [3:0]       data = '0;
    logic             rsp_ready = 1'b0;
    logic             rsp_valid;
    logic [3:0]       rsp_adr;
    logic [3:0]       rsp_data;
    logic             busy;
    logic [CNT_W-1:0] illegal_cnt;
    logic [CNT_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    int m_regs [16];
    int m_q [$];
    int m_clear;
    int m_ill;
    int m_drop;

    always #5 clk = ~clk;

    dut_cmd_slave #(
        .RSP_DEPTH(RSP_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .adr        (adr),
        .data       (data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_adr    (rsp_adr),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .illegal_cnt(illegal_cnt),
        .drop_cnt   (drop_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_q.delete();
        m_clear = 0;
        m_ill   = 0;
        m_drop  = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, int'(rsp_valid), int'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk({tag, ".adr"},  int'(rsp_adr),  m_q[0] / 16);
            chk({tag, ".data"}, int'(rsp_data), m_q[0] % 16);
        end
        chk({tag, ".busy"},    int'(busy),        int'(m_clear > 0));
        chk({tag, ".illegal"}, int'(illegal_cnt), m_ill);
        chk({tag, ".drop"},    int'(drop_cnt),    m_drop);
    endtask

    // One bus edge: the model applies the command's rules, then the DUT is compared after the edge.
    task automatic step(input int c, input int a, input int d, input int rdy, input string tag);
        bit pop;
        bit push;
        cmd       = 4'(c);
        adr       = 4'(a);
        data      = 4'(d);
        rsp_ready = (rdy != 0);
        pop  = (m_q.size() != 0) && (rdy != 0);
        push = 1'b0;
        if (m_clear > 0) begin
            if (c != 0) m_drop = sat(m_drop);
            m_regs[16 - m_clear] = 0;
            m_clear--;
        end else if (c > 4) begin
            m_ill = sat(m_ill);
        end else if (c == 1) begin
            m_regs[a] = d;
        end else if (c == 3) begin
            m_regs[a] = (m_regs[a] + 1) % 16;
        end else if (c == 4) begin
            m_clear = 16;
        end else if (c == 2) begin
            if (m_q.size() < RSP_DEPTH || pop) push = 1'b1;
            else                               m_drop = sat(m_drop);
        end
        if (push) push = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(a * 16 + m_regs[a]);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst       = 1'b1;
        cmd       = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_model(tag);
        chk({tag, ".rsp_adr"},  int'(rsp_adr),  0);
        chk({tag, ".rsp_data"}, int'(rsp_data), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cycles;
        int r;
        int c;

        do_reset("reset");

        step(1, 3, 9, 0, "t1_write");
        step(2, 3, 0, 0, "t1_read");
        chk("t1.valid", int'(rsp_valid), 1);
        chk("t1.adr",   int'(rsp_adr),   3);
        chk("t1.data",  int'(rsp_data),  9);
        step(0, 0, 0, 1, "t1_pop");

        step(1, 5, 15, 0, "t2_write");
        step(3, 5, 0, 0, "t2_inc");
        step(2, 5, 0, 0, "t2_read");
        chk("t2.data",    int'(rsp_data),    0);
        chk("t2.illegal", int'(illegal_cnt), 0);
        step(0, 0, 0, 1, "t2_pop");

        for (int i = 0; i < 6; i++) step(2, i, 0, 0, "t3_fill");
        chk("t3.drop", int'(drop_cnt), 2);
        chk("t3.head", int'(rsp_adr),  0);
        step(2, 6, 0, 1, "t3_pushpop");
        chk("t3.drop_pushpop", int'(drop_cnt), 2);
        chk("t3.head_next",    int'(rsp_adr),  1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "t3_drain");

        for (int i = 0; i < 16; i++) step(1, i, 7, 0, "t4_fill");
        busy_cycles = 0;
        step(4, 0, 0, 0, "t4_clr");
        if (busy) busy_cycles++;
        step(1, 1, 3, 0, "t4_write_in_sweep");
        if (busy) busy_cycles++;
        for (int g = 0; g < 40 && busy; g++) begin
            step(0, 0, 0, 0, "t4_sweep");
            if (busy) busy_cycles++;
        end
        chk("t4.busy_cycles", busy_cycles, 16);
        chk("t4.busy_end",    int'(busy),  0);
        chk("t4.drop",        int'(drop_cnt), 3);
        for (int i = 0; i < 16; i++) begin
            step(2, i, 0, 1, "t4_readback");
            chk("t4.rb_adr",  int'(rsp_adr),  i);
            chk("t4.rb_data", int'(rsp_data), 0);
        end
        step(0, 0, 0, 1, "t4_drain");

        for (int i = 0; i < 300; i++) step(9, i % 16, 0, 1, "t5_illegal");
        chk("t5.illegal_sat", int'(illegal_cnt), CNT_MAX);

        step(1, 10, 5, 1, "t6_write");
        step(4, 0, 0, 1, "t6_clr");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, "t6_sweep");
        do_reset("t6_reset");
        step(2, 10, 0, 0, "t6_read");
        chk("t6.busy",    int'(busy),        0);
        chk("t6.illegal", int'(illegal_cnt), 0);
        chk("t6.drop",    int'(drop_cnt),    0);
        chk("t6.valid",   int'(rsp_valid),   1);
        chk("t6.data",    int'(rsp_data),    0);
        step(0, 0, 0, 1, "t6_pop");

        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 19));
            if (r <= 11)      c = r % 4;
            else if (r == 12) c = 4;
            else if (r <= 14) c = int'($urandom_range(5, 15));
            else              c = 0;
            step(c, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
